// File: rtl/namuru_pkg.sv
// Namuru accumulator bank shared definitions.
// Register offsets, channel stride and helpers for the bank and its users.
package namuru_pkg;

  localparam logic [9:0] NAMURU_REG_STATUS      = 10'h000;
  localparam logic [9:0] NAMURU_REG_MASK        = 10'h004;
  localparam logic [9:0] NAMURU_REG_OVERRUN     = 10'h008;
  localparam logic [9:0] NAMURU_REG_INFO        = 10'h00C;
  localparam logic [9:0] NAMURU_REG_SHADOW_BASE = 10'h100;
  localparam logic [9:0] NAMURU_CH_STRIDE       = 10'h020;
  localparam int         NAMURU_NCH_MAX         = 8;

  function automatic logic [9:0] namuru_shadow_off(
    input int c,
    input int k
  );
    return NAMURU_REG_SHADOW_BASE
         + 10'(c) * NAMURU_CH_STRIDE
         + 10'(k * 4);
  endfunction

endpackage

// File: rtl/namuru_accum_bank_if.sv
// Wishbone classic bus bundle for the accumulator bank.
// master drives the request; slave returns registered data and ack.
interface namuru_accum_bank_if;

  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/namuru_irq_ctrl.sv
// STATUS/MASK/OVERRUN registers and the registered accumulation interrupt.
// Ports: clk/rst, dump set strobes, W1C/autoclear strobes, mask write, state out.
module namuru_irq_ctrl #(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] dump,
  input  logic [NCH-1:0] st_clr,
  input  logic [NCH-1:0] ov_clr,
  input  logic [NCH-1:0] ac_clr,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_d,
  output logic [NCH-1:0] status,
  output logic [NCH-1:0] mask,
  output logic [NCH-1:0] overrun,
  output logic           accum_int
);

  always_ff @(posedge clk) begin
    if (rst) begin
      status    <= '0;
      mask      <= '0;
      overrun   <= '0;
      accum_int <= 1'b0;
    end else begin
      // a dump beats any same-cycle clear
      status  <= (status & ~st_clr & ~ac_clr) | dump;
      // overrun looks at status before this cycle's clear
      overrun <= (overrun & ~ov_clr) | (dump & status);
      if (mask_we)
        mask <= mask_d;
      accum_int <= |(status & mask);
    end
  end

endmodule

// File: rtl/namuru_accum_bank.sv
// N-channel accumulator dump bank with Wishbone classic slave and interrupt.
// Ports: sys_clk/sys_rst, dump strobes, packed acc_i, wb slave, accum_int.
module namuru_accum_bank
  import namuru_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int NACC    = 4,
  parameter int ACC_W   = 16,
  parameter int AUTOCLR = 1
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NCH-1:0]            dump,
  input  logic [NCH*NACC*ACC_W-1:0] acc_i,
  namuru_accum_bank_if.slave        wb,
  output logic                      accum_int
);

  logic [7:0]       widx;
  logic [9:0]       offs;
  logic [2:0]       ci;
  logic [2:0]       ki;
  logic             is_sh;
  logic             req;
  logic             rd_req;
  logic             wr_req;
  logic [NCH-1:0]   st_clr;
  logic [NCH-1:0]   ov_clr;
  logic [NCH-1:0]   ac_clr;
  logic             mask_we;
  logic [NCH-1:0]   status;
  logic [NCH-1:0]   mask;
  logic [NCH-1:0]   overrun;
  logic [ACC_W-1:0] sh;
  logic signed [ACC_W-1:0] sh_s;
  logic signed [31:0]      sh_x;
  logic [31:0]      rd_data;
  logic             unused_ok;

  logic [ACC_W-1:0] shadow [NCH][NACC];

  assign widx  = wb.wb_adr_i[9:2];
  assign offs  = {widx, 2'b00};
  assign ci    = widx[5:3];
  assign ki    = widx[2:0];
  assign is_sh = widx[7:6] == NAMURU_REG_SHADOW_BASE[9:8];

  // ack in flight blocks the next request: held stb acks every 2nd cycle
  assign req    = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
  assign rd_req = req & ~wb.wb_we_i;
  assign wr_req = req & wb.wb_we_i & wb.wb_sel_i[0];

  assign unused_ok = ^{wb.wb_adr_i[31:10], wb.wb_adr_i[1:0],
                       wb.wb_sel_i[3:1], wb.wb_dat_i[31:NCH]};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NACC; k++)
          shadow[c][k] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (dump[c])
          for (int k = 0; k < NACC; k++)
            shadow[c][k] <= acc_i[(c*NACC+k)*ACC_W +: ACC_W];
    end
  end

  always_comb begin
    sh = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NACC; k++)
        if (ci == 3'(c) && ki == 3'(k))
          sh = shadow[c][k];
  end

  assign sh_s = sh;
  assign sh_x = sh_s;

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      is_sh:
        rd_data = sh_x;
      offs == NAMURU_REG_STATUS:
        rd_data = 32'(status);
      offs == NAMURU_REG_MASK:
        rd_data = 32'(mask);
      offs == NAMURU_REG_OVERRUN:
        rd_data = 32'(overrun);
      offs == NAMURU_REG_INFO:
        rd_data = {8'd0, 8'(ACC_W), 8'(NACC), 8'(NCH)};
      default:
        rd_data = '0;
    endcase
  end

  always_comb begin
    st_clr  = '0;
    ov_clr  = '0;
    mask_we = 1'b0;
    if (wr_req) begin
      if (offs == NAMURU_REG_STATUS)
        st_clr = wb.wb_dat_i[NCH-1:0];
      if (offs == NAMURU_REG_OVERRUN)
        ov_clr = wb.wb_dat_i[NCH-1:0];
      mask_we = offs == NAMURU_REG_MASK;
    end
  end

  // reading the last accumulator of a channel consumes its new-data flag
  always_comb begin
    ac_clr = '0;
    if (AUTOCLR != 0 && rd_req && is_sh && ki == 3'(NACC-1))
      for (int c = 0; c < NCH; c++)
        if (ci == 3'(c))
          ac_clr[c] = 1'b1;
  end

  namuru_irq_ctrl #(
    .NCH (NCH)
  ) u_irq (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .dump      (dump),
    .st_clr    (st_clr),
    .ov_clr    (ov_clr),
    .ac_clr    (ac_clr),
    .mask_we   (mask_we),
    .mask_d    (wb.wb_dat_i[NCH-1:0]),
    .status    (status),
    .mask      (mask),
    .overrun   (overrun),
    .accum_int (accum_int)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      wb.wb_ack_o <= req;
      wb.wb_dat_o <= rd_req ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_namuru_accum_bank.sv
// Self-checking bench for namuru_accum_bank.
// Directed steps; read expectations flow through a scoreboard queue.
module tb_namuru_accum_bank;
  import namuru_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   dump;
  logic [255:0] acc;
  logic         accum_int;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];

  namuru_accum_bank_if wb ();

  namuru_accum_bank #(
    .NCH     (4),
    .NACC    (4),
    .ACC_W   (16),
    .AUTOCLR (1)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .dump      (dump),
    .acc_i     (acc),
    .wb        (wb),
    .accum_int (accum_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic set_acc(input int c, input int k, input logic [15:0] v);
    acc[(c*4+k)*16 +: 16] = v;
  endtask

  task automatic bus_idle();
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_sel_i = 4'h0;
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
  endtask

  task automatic wait_ack(input string tag, output bit got);
    int lat;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (wb.wb_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_lat"}, lat, got ? 32'd1 : 32'd99);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] want,
                         input string tag);
    bit got;
    logic [31:0] e;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    wb.wb_adr_i = a;
    wb.wb_we_i  = 1'b0;
    wb.wb_sel_i = 4'hF;
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    wait_ack(tag, got);
    e = exp_q.pop_front();
    if (got)
      chk(tag, wb.wb_dat_o, e);
    bus_idle();
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input string tag);
    bit got;
    @(posedge clk);
    #1;
    wb.wb_adr_i = a;
    wb.wb_dat_i = d;
    wb.wb_we_i  = 1'b1;
    wb.wb_sel_i = 4'h1;
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    wait_ack(tag, got);
    bus_idle();
  endtask

  task automatic pulse(input logic [3:0] m);
    @(posedge clk);
    #1;
    dump = m;
    @(posedge clk);
    #1;
    dump = '0;
  endtask

  initial begin
    int acks;
    int consec;
    logic prev;

    rst  = 1'b1;
    dump = '0;
    acc  = '0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_ack", 32'(wb.wb_ack_o), 32'd0);
    chk("rst_dat", wb.wb_dat_o, 32'd0);
    chk("rst_irq", 32'(accum_int), 32'd0);
    wb_read(32'(NAMURU_REG_INFO), 32'h0010_0404, "info");
    @(posedge clk);
    #1;
    chk("dat_idle", wb.wb_dat_o, 32'd0);
    wb_read(32'(NAMURU_REG_STATUS), 32'd0, "rst_status");
    wb_read(32'(NAMURU_REG_MASK), 32'd0, "rst_mask");
    wb_read(32'(NAMURU_REG_OVERRUN), 32'd0, "rst_ovr");

    // channel 2 dump, sign extension, interrupt latency
    set_acc(2, 0, 16'h8001);
    set_acc(2, 1, 16'h7FFF);
    set_acc(2, 2, 16'h1234);
    set_acc(2, 3, 16'hFFFF);
    wb_write(32'(NAMURU_REG_MASK), 32'h4, "mask4");
    pulse(4'h4);
    chk("irq_lat1", 32'(accum_int), 32'd0);
    @(posedge clk);
    #1;
    chk("irq_lat2", 32'(accum_int), 32'd1);
    wb_read(32'(namuru_shadow_off(2, 0)), 32'hFFFF_8001, "sh20");
    wb_read(32'(namuru_shadow_off(2, 1)), 32'h0000_7FFF, "sh21");
    wb_read(32'(NAMURU_REG_STATUS), 32'h4, "status4");
    wb_read(32'(NAMURU_REG_MASK), 32'h4, "mask_rd");
    wb_write(32'(NAMURU_REG_STATUS), 32'h4, "w1c4");
    repeat (2) @(posedge clk);
    #1;
    chk("irq_clr", 32'(accum_int), 32'd0);

    // overrun on channel 0
    set_acc(0, 0, 16'h0011);
    pulse(4'h1);
    pulse(4'h1);
    wb_read(32'(NAMURU_REG_OVERRUN), 32'h1, "ovr1");
    wb_write(32'(NAMURU_REG_OVERRUN), 32'h1, "ovr_w1c");
    wb_read(32'(NAMURU_REG_OVERRUN), 32'h0, "ovr0");
    wb_read(32'(NAMURU_REG_STATUS), 32'h1, "status1");
    wb_write(32'(NAMURU_REG_STATUS), 32'h1, "w1c1");

    // dump and W1C of the same bit in one cycle
    set_acc(1, 0, 16'h0AAA);
    pulse(4'h2);
    set_acc(1, 0, 16'h0BBB);
    @(posedge clk);
    #1;
    wb.wb_adr_i = 32'(NAMURU_REG_STATUS);
    wb.wb_dat_i = 32'h2;
    wb.wb_we_i  = 1'b1;
    wb.wb_sel_i = 4'h1;
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    dump        = 4'h2;
    @(posedge clk);
    #1;
    dump = '0;
    chk("race_ack", 32'(wb.wb_ack_o), 32'd1);
    bus_idle();
    wb_read(32'(NAMURU_REG_STATUS), 32'h2, "race_status");
    wb_read(32'(namuru_shadow_off(1, 0)), 32'h0000_0BBB, "race_sh");
    wb_read(32'(NAMURU_REG_OVERRUN), 32'h2, "race_ovr");
    wb_write(32'(NAMURU_REG_STATUS), 32'hF, "clr_st");
    wb_write(32'(NAMURU_REG_OVERRUN), 32'hF, "clr_ov");
    wb_read(32'(NAMURU_REG_STATUS), 32'h0, "status0");

    // autoclear on channel 3 and out-of-range reads
    set_acc(3, 3, 16'hC000);
    wb_write(32'(NAMURU_REG_MASK), 32'h8, "mask8");
    pulse(4'h8);
    @(posedge clk);
    #1;
    chk("irq3_on", 32'(accum_int), 32'd1);
    wb_read(32'h16C, 32'hFFFF_C000, "sh33");
    chk("irq3_hold", 32'(accum_int), 32'd1);
    @(posedge clk);
    #1;
    chk("irq3_off", 32'(accum_int), 32'd0);
    wb_read(32'(NAMURU_REG_STATUS), 32'h0, "autoclr");
    wb_read(32'h1E0, 32'h0, "ch7");
    wb_read(32'h3FC, 32'h0, "unmapped");
    wb_read(32'h110, 32'h0, "k4");
    wb_write(32'(NAMURU_REG_INFO), 32'hFFFF_FFFF, "info_wr");
    wb_write(32'h0F0, 32'hFFFF_FFFF, "unm_wr");
    wb_read(32'(NAMURU_REG_INFO), 32'h0010_0404, "info_ro");
    wb_write(32'(NAMURU_REG_MASK), 32'hFF, "mask_ff");
    wb_read(32'(NAMURU_REG_MASK), 32'hF, "mask_hi");

    // held request: one ack every other cycle
    @(posedge clk);
    #1;
    wb.wb_adr_i = 32'(NAMURU_REG_INFO);
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    acks   = 0;
    consec = 0;
    prev   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (wb.wb_ack_o) begin
        acks++;
        if (prev)
          consec++;
      end
      prev = wb.wb_ack_o;
    end
    bus_idle();
    chk("held_acks", 32'(acks), 32'd3);
    chk("held_consec", 32'(consec), 32'd0);

    // reset with a request pending
    wb_write(32'(NAMURU_REG_MASK), 32'h1, "mask1");
    set_acc(0, 0, 16'h5555);
    pulse(4'h1);
    @(posedge clk);
    #1;
    wb.wb_adr_i = 32'(NAMURU_REG_STATUS);
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ack", 32'(wb.wb_ack_o), 32'd0);
    rst = 1'b0;
    bus_idle();
    @(posedge clk);
    #1;
    chk("rst_mid_ack2", 32'(wb.wb_ack_o), 32'd0);
    chk("rst_mid_irq", 32'(accum_int), 32'd0);
    wb_read(32'(NAMURU_REG_STATUS), 32'h0, "rst2_status");
    wb_read(32'(NAMURU_REG_MASK), 32'h0, "rst2_mask");
    wb_read(32'(NAMURU_REG_OVERRUN), 32'h0, "rst2_ovr");
    wb_read(32'(namuru_shadow_off(0, 0)), 32'h0, "rst2_sh");
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
